// File: rtl/ones_pkg.sv
// Shared definitions for the ones-word generator and its ones-counter counterpart.
package ones_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 5;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DONE
    } state_e;

    // Reference population count used to check generated words
    function automatic logic [CNT_W-1:0] popcount16(input logic [15:0] w);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int k = 0; k < 16; k++) begin
            n = n + {4'b0, w[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ones_word_gen_if.sv
// Command/result bundle between a stimulus driver and the ones-word generator.
interface ones_word_gen_if;

    logic        start;
    logic [4:0]  count_in;
    logic        seed_load;
    logic [15:0] seed;
    logic        busy;
    logic        done;
    logic        bit_out;
    logic [15:0] word_out;

    // Driver side: issues requests, observes the generated word
    modport master (
        output start,
        output count_in,
        output seed_load,
        output seed,
        input  busy,
        input  done,
        input  bit_out,
        input  word_out
    );

    // Generator side
    modport slave (
        input  start,
        input  count_in,
        input  seed_load,
        input  seed,
        output busy,
        output done,
        output bit_out,
        output word_out
    );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with seed load; a zero seed is replaced by the default.
module lfsr16 #(
    parameter logic [15:0] DEFAULT_SEED = ones_pkg::DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] q_o
);

    import ones_pkg::*;

    logic [15:0] q_q;
    logic        fb;

    assign fb  = ^(q_q & LFSR_TAPS);
    assign q_o = q_q;

    // Reset, then load, then step; the all-zero lock-up state is never loaded
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= DEFAULT_SEED;
        end else if (load_i) begin
            q_q <= (seed_i == 16'h0000) ? DEFAULT_SEED : seed_i;
        end else if (step_i) begin
            q_q <= {q_q[14:0], fb};
        end
    end

endmodule

// File: rtl/ones_word_gen.sv
// Builds a 16-bit word LSB first with exactly the requested number of ones;
// placement follows the LFSR, but ones are forced once remaining positions run out.
module ones_word_gen #(
    parameter int unsigned WIDTH        = ones_pkg::WIDTH,
    parameter logic [15:0] DEFAULT_SEED = ones_pkg::DEFAULT_SEED
) (
    input  logic              clk_i,
    input  logic              reset_i,
    ones_word_gen_if.slave    gen_if
);

    import ones_pkg::*;

    state_e           state_q;
    logic [CNT_W-1:0] r_q;
    logic [3:0]       i_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_q;

    logic [15:0]      lfsr_q;
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] cnt_sat;
    logic             gen_bit;
    logic [WIDTH-1:0] shift_d;
    logic [CNT_W-1:0] r_d;

    lfsr16 #(
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (gen_if.seed_load && (state_q == IDLE)),
        .seed_i  (gen_if.seed),
        .step_i  (state_q == GEN),
        .q_o     (lfsr_q)
    );

    // Bit decision for the current step: forced 0 when no ones remain,
    // forced 1 when every remaining position must be a one, else random
    always_comb begin
        p       = CNT_W'(WIDTH) - {1'b0, i_q};
        cnt_sat = (gen_if.count_in > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : gen_if.count_in;
        if (r_q == '0) begin
            gen_bit = 1'b0;
        end else if (r_q >= p) begin
            gen_bit = 1'b1;
        end else begin
            gen_bit = lfsr_q[0];
        end
        shift_d      = shift_q;
        shift_d[i_q] = gen_bit;
        r_d          = r_q - {{(CNT_W-1){1'b0}}, gen_bit};
    end

    // Control FSM with counters, shift register and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            r_q     <= '0;
            i_q     <= '0;
            shift_q <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    bit_q  <= 1'b0;
                    if (gen_if.start) begin
                        r_q     <= cnt_sat;
                        i_q     <= '0;
                        shift_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= GEN;
                    end
                end
                GEN: begin
                    bit_q   <= gen_bit;
                    shift_q <= shift_d;
                    r_q     <= r_d;
                    i_q     <= i_q + 4'd1;
                    if (i_q == 4'(WIDTH - 1)) begin
                        word_q  <= shift_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    bit_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gen_if.busy     = busy_q;
    assign gen_if.done     = done_q;
    assign gen_if.bit_out  = bit_q;
    assign gen_if.word_out = word_q;

endmodule

// File: tb/tb_ones_word_gen.sv
// Directed bench for ones_word_gen: exact popcount, saturation, timing, ignored
// starts, seed handling and mid-word reset.
module tb_ones_word_gen;

    import ones_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ones_word_gen_if bus ();

    ones_word_gen #(
        .WIDTH        (16),
        .DEFAULT_SEED (16'hACE1)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .gen_if  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one word from IDLE (at a negedge) and watch it for 40 cycles.
    // j counts negedges after the start edge T: bit i appears at j=i+1, done at j=16.
    task automatic gen_word(input logic [4:0] cnt, input logic load, input logic [15:0] sd,
                            input logic ign, output logic [15:0] word, output logic [15:0] bits,
                            output int busy_cnt, output int done_j, output int done_cnt,
                            output logic held);
        logic [15:0] prev;
        prev     = bus.word_out;
        held     = 1'b1;
        busy_cnt = 0;
        done_j   = -1;
        done_cnt = 0;
        bits     = '0;
        bus.start     = 1'b1;
        bus.count_in  = cnt;
        bus.seed_load = load;
        bus.seed      = sd;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        if (ign) bus.count_in = 5'd16;
        for (int j = 0; j < 40; j++) begin
            bus.start = ign && (j == 3 || j == 10 || j == 16);
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                if (bus.word_out !== prev) held = 1'b0;
            end
            if (j >= 1 && j <= 16) bits[j-1] = bus.bit_out;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_j < 0) done_j = j;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        word = bus.word_out;
    endtask

    logic [15:0] w, b, w1, w2, w3;
    int          bc, dj, dc, extra;
    logic        h;

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.count_in  = '0;
        bus.seed_load = 1'b0;
        bus.seed      = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_bit", {31'b0, bus.bit_out}, 32'd0);
        check("rst_word", {16'b0, bus.word_out}, 32'h0000);
        check("rst_lfsr", {16'b0, dut.u_lfsr.q_o}, 32'hACE1);
        reset = 1'b0;
        @(negedge clk);

        // Zero count: timing and an all-zero word
        gen_word(5'd0, 1'b0, 16'h0, 1'b0, w, b, bc, dj, dc, h);
        check("zero_word", {16'b0, w}, 32'h0000);
        check("zero_done_lat", dj, 32'd16);
        check("zero_done_cnt", dc, 32'd1);
        check("zero_busy_cycles", bc, 32'd16);

        // Full and saturated counts
        gen_word(5'd16, 1'b0, 16'h0, 1'b0, w, b, bc, dj, dc, h);
        check("full16_word", {16'b0, w}, 32'hFFFF);
        check("full16_bits", {16'b0, b}, 32'hFFFF);
        check("full16_done_lat", dj, 32'd16);
        gen_word(5'd31, 1'b0, 16'h0, 1'b0, w, b, bc, dj, dc, h);
        check("sat31_word", {16'b0, w}, 32'hFFFF);
        check("sat31_bits", {16'b0, b}, 32'hFFFF);
        check("sat31_word_held", {31'b0, h}, 32'd1);

        // Exact counts from seed 1234, loaded together with the first start
        gen_word(5'd1, 1'b1, 16'h1234, 1'b0, w, b, bc, dj, dc, h);
        check("exact1_pop", {27'b0, popcount16(w)}, 32'd1);
        check("exact1_bits", {16'b0, b}, {16'b0, w});
        check("exact1_held", {31'b0, h}, 32'd1);
        gen_word(5'd5, 1'b0, 16'h0, 1'b0, w, b, bc, dj, dc, h);
        check("exact5_pop", {27'b0, popcount16(w)}, 32'd5);
        check("exact5_bits", {16'b0, b}, {16'b0, w});
        gen_word(5'd8, 1'b0, 16'h0, 1'b0, w, b, bc, dj, dc, h);
        check("exact8_pop", {27'b0, popcount16(w)}, 32'd8);
        check("exact8_bits", {16'b0, b}, {16'b0, w});
        gen_word(5'd15, 1'b0, 16'h0, 1'b0, w, b, bc, dj, dc, h);
        check("exact15_pop", {27'b0, popcount16(w)}, 32'd15);
        check("exact15_bits", {16'b0, b}, {16'b0, w});

        // Zero seed substitutes the default
        bus.seed_load = 1'b1;
        bus.seed      = 16'h0000;
        @(negedge clk);
        bus.seed_load = 1'b0;
        check("seed0_lfsr", {16'b0, dut.u_lfsr.q_o}, 32'hACE1);

        // Determinism and carry-over of LFSR state
        gen_word(5'd7, 1'b1, 16'h0000, 1'b0, w1, b, bc, dj, dc, h);
        gen_word(5'd7, 1'b1, 16'h0000, 1'b0, w2, b, bc, dj, dc, h);
        gen_word(5'd7, 1'b0, 16'h0000, 1'b0, w3, b, bc, dj, dc, h);
        check("det_pop1", {27'b0, popcount16(w1)}, 32'd7);
        check("det_same", {16'b0, w2}, {16'b0, w1});
        check("det_differs", {31'b0, (w3 != w1)}, 32'd1);
        check("det_pop3", {27'b0, popcount16(w3)}, 32'd7);

        // Starts during GEN and DONE are ignored; count_in is changed meanwhile
        gen_word(5'd3, 1'b0, 16'h0, 1'b1, w, b, bc, dj, dc, h);
        check("ign_done_cnt", dc, 32'd1);
        check("ign_pop", {27'b0, popcount16(w)}, 32'd3);
        check("ign_busy_cycles", bc, 32'd16);

        // Reset at step 8 discards the partial word
        bus.count_in = 5'd9;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", {31'b0, bus.busy}, 32'd0);
        check("rstmid_done", {31'b0, bus.done}, 32'd0);
        check("rstmid_word", {16'b0, bus.word_out}, 32'h0000);
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done === 1'b1) extra++;
            @(negedge clk);
        end
        check("rstmid_no_done", extra, 32'd0);
        gen_word(5'd4, 1'b0, 16'h0, 1'b0, w, b, bc, dj, dc, h);
        check("after_rst_pop", {27'b0, popcount16(w)}, 32'd4);
        check("after_rst_done_lat", dj, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ones_word_gen.md
# ones_word_gen

Generates a 16-bit test word containing exactly a requested number of 1s. It is the counterpart of the serial ones-counter: the generator produces the word and the counter checks its population count. The word is built bit-serially, LSB first, one bit per clock. Bit placement is pseudo-random and driven by an internal 16-bit LFSR, but the final count is always exact. The block sits in the stimulus/self-check path and drives the counter's data input.

## Interface
Parameters:
- WIDTH, 16, word width; only 16 is supported.
- DEFAULT_SEED, 16'hACE1, LFSR value after reset and the substitute for a zero seed.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset; one clock, one synchronous active-high reset.
- start  input  1  request to generate a word; accepted only in IDLE.
- count_in  input  5  requested number of 1s; values above 16 saturate to 16.
- seed_load  input  1  loads seed into the LFSR; accepted only in IDLE.
- seed  input  16  LFSR seed.
- busy  output  1  high while in GEN.
- done  output  1  one-cycle pulse when word_out becomes valid; the equivalent of the counter's end flag.
- bit_out  output  1  the bit written in the current GEN step.
- word_out  output  16  completed word; held until the next completion.

## Operation
- States:
  - IDLE: waits for start.
  - GEN: 16 steps, bit index i = 0..15.
  - DONE: lasts one cycle, then returns to IDLE.
- Start acceptance (IDLE only):
  - start=1 latches r = min(count_in, 16), clears the shift register, sets i=0 and enters GEN.
  - start in GEN or DONE is ignored; it is not queued.
- Seed loading (IDLE only):
  - seed_load=1 loads seed into the LFSR; seed == 0 loads DEFAULT_SEED.
  - When seed_load and start are both high, the seed loads first and that LFSR value is used for bit 0.
  - seed_load outside IDLE is ignored.
- Bit rule for each GEN step, with p = 16 − i positions remaining:
  - r == 0: bit = 0.
  - r >= p: bit = 1.
  - otherwise: bit = lfsr[0].
  - When bit = 1, r decrements.
  - The bit is written to position i and i increments.
  - Result: popcount(word) == min(count_in, 16) for every seed.
- LFSR:
  - Fibonacci, polynomial x^16 + x^14 + x^13 + x^11 + 1.
  - Shifts one step per GEN cycle only; it holds in IDLE and DONE.
  - Its state carries over between words, so back-to-back words differ.
- Completion: on the edge that writes bit 15, word_out is loaded with the full word, the state moves to DONE and done is set.
- Arithmetic: r is 5 bits and never underflows, because r <= p holds by construction. i is 4 bits and wraps only at GEN exit.
- Reset values:
  - state = IDLE; busy, done, bit_out = 0.
  - word_out = 16'h0000; LFSR = DEFAULT_SEED; r = 0, i = 0.
- Reset mid-operation: an asserted reset overrides everything in the same cycle. The partial word is discarded and done does not pulse.

## Timing
- start sampled high at edge T:
  - busy = 1 from T+1 through T+16.
  - Bit i is written at edge T+1+i; bit_out shows it during cycle T+1+i.
- Edge T+16:
  - word_out is valid.
  - done = 1 for exactly the cycle following T+16.
  - busy falls.
- Next start is accepted at edge T+18 at the earliest, from IDLE. Start-to-done latency is 16 cycles; throughput is one word per 18 cycles.
- word_out does not change during GEN; it updates only at completion.
- Every output is registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package ones_pkg:
  - WIDTH = 16 and CNT_W = 5.
  - LFSR tap mask 16'hB400 and DEFAULT_SEED.
  - State enum {IDLE, GEN, DONE}.
  - The popcount reference function; the bench and the counter reuse it.
- Sub-module lfsr16:
  - Ports: clk, reset, load, seed, step, q.
  - Handles the zero-seed substitution.
- Top level: the FSM, r/i counters, shift register and output registers.

## Test plan
- Zero count: reset, then start with count_in = 0 → word_out = 16'h0000, done pulses exactly 16 cycles after the start edge, busy was high for 16 cycles.
- Full and saturated count:
  - count_in = 16 → word_out = 16'hFFFF.
  - count_in = 31 → word_out = 16'hFFFF.
  - bit_out = 1 on all 16 steps.
- Exact count:
  - seed = 16'h1234; run count_in = 1, 5, 8 and 15 back-to-back.
  - Each word has popcount equal to its count.
  - Feeding each word into the ones-counter gives a matching result.
- Determinism: seed_load with 16'h0000 → the LFSR holds 16'hACE1. Two runs with count_in = 7 from the same seed give identical words. A second run without reloading the seed gives a word that differs and still has popcount 7.
- Ignored start: assert start at GEN steps 3 and 10 and in the DONE cycle → exactly one done pulse, and word_out matches the original count_in.
- Reset mid-GEN: reset at step 8 → the next cycle shows busy = 0, done = 0 and word_out = 16'h0000, with no done pulse. A fresh start with count_in = 4 completes normally.
